// File: rtl/dual_port_ram_param.sv
// Simple dual-port RAM (one write port, one read port, single clock) with byte-lane
// write enables, 1- or 2-cycle read latency, selectable collision policy and a post-reset clear sweep.
module dual_port_ram_param #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 4,
   parameter int RD_LAT     = 1,
   parameter int BYP_MODE   = 0,
   parameter int CLR_ON_RST = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   din,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   dout,
   output logic                dout_vld,
   output logic                coll,
   output logic                busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int LANES = DATA_W / 8;

   typedef enum logic {CLEAR, RUN} state_t;
   localparam state_t RST_STATE = (CLR_ON_RST != 0) ? CLEAR : RUN;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                clr_we, wr_go, rd_go, hit;
   logic [DATA_W-1:0]   be_mask, rd_old, rd_word;

   // Sweep control: one word zeroed per edge; the edge that clears the last word enters RUN.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + ADDR_W'(1);
         if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RST_STATE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      clr_we  = (state_q == CLEAR) && !rst;
      wr_go   = (state_q == RUN) && wr_en && !rst;
      rd_go   = (state_q == RUN) && rd_en && !rst;
      hit     = wr_go && rd_go && (wr_addr == rd_addr);
      be_mask = '0;
      for (int i = 0; i < LANES; i++) be_mask[8*i +: 8] = {8{wr_be[i]}};
      rd_old  = mem[rd_addr];
      rd_word = rd_old;
      if (BYP_MODE != 0 && hit) rd_word = (rd_old & ~be_mask) | (din & be_mask);
   end

   // NOTE: the array has no reset so it maps onto block RAM; zeroing is done by the sweep instead.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_cnt_q] <= '0;
      end else if (wr_go) begin
         for (int i = 0; i < LANES; i++)
            if (wr_be[i]) mem[wr_addr][8*i +: 8] <= din[8*i +: 8];
      end
   end

   // Source feeding the output register: the raw read (RD_LAT=1) or one extra stage (RD_LAT=2).
   logic              src_vld, src_coll;
   logic [DATA_W-1:0] src_data;

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              s1_vld_q, s1_vld_d, s1_coll_q, s1_coll_d;
         logic [DATA_W-1:0] s1_data_q, s1_data_d;

         always_comb begin
            s1_vld_d  = rd_go;
            s1_coll_d = hit;
            s1_data_d = s1_data_q;
            if (rd_go) s1_data_d = rd_word;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1_vld_q  <= 1'b0;
               s1_coll_q <= 1'b0;
               s1_data_q <= '0;
            end else begin
               s1_vld_q  <= s1_vld_d;
               s1_coll_q <= s1_coll_d;
               s1_data_q <= s1_data_d;
            end
         end

         assign src_vld  = s1_vld_q;
         assign src_coll = s1_coll_q;
         assign src_data = s1_data_q;
      end else begin : g_lat1
         assign src_vld  = rd_go;
         assign src_coll = hit;
         assign src_data = rd_word;
      end
   endgenerate

   logic              dout_vld_q, dout_vld_d, coll_q, coll_d;
   logic [DATA_W-1:0] dout_q, dout_d;

   always_comb begin
      dout_vld_d = src_vld;
      coll_d     = src_vld && src_coll;
      dout_d     = dout_q;
      if (src_vld) dout_d = src_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_vld_q <= 1'b0;
         coll_q     <= 1'b0;
         dout_q     <= '0;
      end else begin
         dout_vld_q <= dout_vld_d;
         coll_q     <= coll_d;
         dout_q     <= dout_d;
      end
   end

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign coll     = coll_q;
   assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Drives two RAM instances (RD_LAT=1/write-old, RD_LAT=2/write-first) with shared stimulus and
// compares both against a word-array reference model with per-instance read latency.
module tb_dual_port_ram_param;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int LANES  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wr_en = 1'b0, rd_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
   logic [DATA_W-1:0] din = '0;
   logic [LANES-1:0]  wr_be = '0;

   logic [DATA_W-1:0] dout_a, dout_b;
   logic              vld_a, vld_b, coll_a, coll_b, busy_a, busy_b;

   always #5 clk = ~clk;

   dual_port_ram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1), .BYP_MODE(0), .CLR_ON_RST(1)) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .din(din), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout_a), .dout_vld(vld_a), .coll(coll_a), .busy(busy_a));

   dual_port_ram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2), .BYP_MODE(1), .CLR_ON_RST(1)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .din(din), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout_b), .dout_vld(vld_b), .coll(coll_b), .busy(busy_b));

   typedef struct {
      logic              vld;
      logic              coll;
      logic [DATA_W-1:0] data;
   } rd_ev_t;

   int                errors = 0;
   int                checks = 0;
   logic [DATA_W-1:0] ref_mem [DEPTH];
   int                clear_left = 0;
   rd_ev_t            pend_b;
   logic [DATA_W-1:0] exp_dout_a = '0, exp_dout_b = '0;
   logic              exp_vld_a = 1'b0, exp_coll_a = 1'b0, exp_vld_b = 1'b0, exp_coll_b = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic exp_busy;
      exp_busy = (clear_left > 0);
      check("a.dout",     32'(dout_a), 32'(exp_dout_a));
      check("a.dout_vld", 32'(vld_a),  32'(exp_vld_a));
      check("a.coll",     32'(coll_a), 32'(exp_coll_a));
      check("a.busy",     32'(busy_a), 32'(exp_busy));
      check("b.dout",     32'(dout_b), 32'(exp_dout_b));
      check("b.dout_vld", 32'(vld_b),  32'(exp_vld_b));
      check("b.coll",     32'(coll_b), 32'(exp_coll_b));
      check("b.busy",     32'(busy_b), 32'(exp_busy));
   endtask

   // One clock of stimulus; the model decides what each instance must show afterwards.
   task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] d,
                       input logic [LANES-1:0] be, input logic re, input logic [ADDR_W-1:0] ra);
      rd_ev_t            ev_a, ev_b;
      logic [DATA_W-1:0] old_word, merged;
      logic              active;
      wr_en = we; wr_addr = wa; din = d; wr_be = be; rd_en = re; rd_addr = ra;
      @(posedge clk);
      active   = (clear_left == 0);
      old_word = ref_mem[ra];
      merged   = old_word;
      for (int i = 0; i < LANES; i++) if (be[i]) merged[8*i +: 8] = d[8*i +: 8];
      ev_a.vld  = active && re;
      ev_a.coll = ev_a.vld && we && (wa == ra);
      ev_a.data = old_word;
      ev_b      = ev_a;
      if (ev_b.coll) ev_b.data = merged;
      if (active && we)
         for (int i = 0; i < LANES; i++) if (be[i]) ref_mem[wa][8*i +: 8] = d[8*i +: 8];
      if (!active) clear_left--;
      exp_vld_a  = ev_a.vld;
      exp_coll_a = ev_a.coll;
      if (ev_a.vld) exp_dout_a = ev_a.data;
      exp_vld_b  = pend_b.vld;
      exp_coll_b = pend_b.coll;
      if (pend_b.vld) exp_dout_b = pend_b.data;
      pend_b = ev_b;
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic flood(input int n);
      for (int i = 0; i < n; i++)
         step(1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
   endtask

   // Asserts rst mid-cycle, checks the asynchronous response, then releases on a falling edge.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      wr_en = 1'b0; rd_en = 1'b0;
      #1;
      exp_dout_a = '0; exp_vld_a = 1'b0; exp_coll_a = 1'b0;
      exp_dout_b = '0; exp_vld_b = 1'b0; exp_coll_b = 1'b0;
      pend_b     = '{vld: 1'b0, coll: 1'b0, data: '0};
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      check_outputs();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_outputs();
   endtask

   initial begin
      logic [ADDR_W-1:0] wa, ra;
      pend_b = '{vld: 1'b0, coll: 1'b0, data: '0};
      do_reset();

      // Requests during the sweep are ignored; then every word reads back as zero.
      flood(DEPTH);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, '0, 1'b1, 4'(i));
      idle(2);

      // Fill with 0x1100+i and read back-to-back.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 4'(i), 16'h1100 + 16'(i), 2'b11, 1'b0, '0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, '0, 1'b1, 4'(i));
      idle(2);

      // Single-lane write merges into the stored word.
      step(1'b1, 4'd5, 16'hAAAA, 2'b11, 1'b0, '0);
      step(1'b1, 4'd5, 16'h1234, 2'b01, 1'b0, '0);
      step(1'b0, '0, '0, '0, 1'b1, 4'd5);
      idle(2);

      // Full-word collision, then a plain read of the same word.
      step(1'b1, 4'd3, 16'hBEEF, 2'b11, 1'b0, '0);
      step(1'b1, 4'd3, 16'h5A5A, 2'b11, 1'b1, 4'd3);
      step(1'b0, '0, '0, '0, 1'b1, 4'd3);
      idle(2);

      // Partial-lane collision.
      step(1'b1, 4'd7, 16'hBEEF, 2'b11, 1'b0, '0);
      step(1'b1, 4'd7, 16'h1234, 2'b10, 1'b1, 4'd7);
      idle(2);

      // Write then read the next edge; wr_en with no lanes enabled.
      step(1'b1, 4'd9, 16'hC0DE, 2'b11, 1'b0, '0);
      step(1'b1, 4'd9, 16'hFFFF, 2'b00, 1'b1, 4'd9);
      step(1'b0, '0, '0, '0, 1'b1, 4'd9);
      idle(2);

      // Reset three reads into a burst, then again partway through the sweep.
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 4'(i));
      do_reset();
      flood(5);
      do_reset();
      flood(DEPTH);

      // Random traffic with frequent same-address collisions.
      for (int n = 0; n < 400; n++) begin
         wa = 4'($urandom);
         ra = ($urandom_range(0, 1) == 0) ? wa : 4'($urandom);
         step(1'($urandom), wa, 16'($urandom), 2'($urandom), 1'($urandom), ra);
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
